// File: rtl/fsm_dispensador_multi_if.sv
// Signal bundle for the multi-channel dispenser: per-channel request, fault and
// clear inputs, plus actuator, alarm, pending, state and grant outputs.
// With DISPENSADOR_CONTADOR_EN defined, the bundle also carries the per-channel
// dose counters (doses, 8 bits per channel).
interface fsm_dispensador_multi_if #(
    parameter int N_CANAIS = 4
);
    localparam int SEL_W = (N_CANAIS > 2) ? $clog2(N_CANAIS) : 1;

    logic [N_CANAIS-1:0] CR;
    logic [N_CANAIS-1:0] BZ;
    logic [N_CANAIS-1:0] CLR;
    logic [N_CANAIS-1:0] AD;
    logic [N_CANAIS-1:0] A;
    logic [N_CANAIS-1:0] pendente;
    logic [1:0]          state;
    logic [SEL_W-1:0]    sel;
`ifdef DISPENSADOR_CONTADOR_EN
    logic [N_CANAIS*8-1:0] doses;

    modport master (output CR, BZ, CLR, input AD, A, pendente, state, sel, doses);
    modport slave  (input CR, BZ, CLR, output AD, A, pendente, state, sel, doses);
`else
    modport master (output CR, BZ, CLR, input AD, A, pendente, state, sel);
    modport slave  (input CR, BZ, CLR, output AD, A, pendente, state, sel);
`endif
endinterface

// File: rtl/fsm_dispensador_multi.sv
// Multi-channel dispenser: N_CANAIS channels share one actuator mechanism.
// Requests are latched per channel and granted round-robin; each grant drives
// the channel's actuator for TEMPO_ACIONAR cycles followed by TEMPO_PAUSA idle
// cycles. A fault latches a per-channel alarm that software can clear.
// Optional macro DISPENSADOR_CONTADOR_EN adds saturating 8-bit dose counters.
module fsm_dispensador_multi #(
    parameter int N_CANAIS      = 4,
    parameter int LARG_TEMPO    = 8,
    parameter int TEMPO_ACIONAR = 10,
    parameter int TEMPO_PAUSA   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    fsm_dispensador_multi_if.slave bus
);
    localparam int SEL_W = (N_CANAIS > 2) ? $clog2(N_CANAIS) : 1;
    localparam logic [LARG_TEMPO-1:0] T_ACIONAR = LARG_TEMPO'(TEMPO_ACIONAR - 1);
    localparam logic [LARG_TEMPO-1:0] T_PAUSA   = LARG_TEMPO'(TEMPO_PAUSA - 1);
    localparam logic [LARG_TEMPO-1:0] T_UM      = LARG_TEMPO'(1);
    localparam logic [N_CANAIS-1:0]   BIT0      = N_CANAIS'(1);

    typedef enum logic [1:0] {
        ESPERAR   = 2'b00,
        RESERVADO = 2'b01,
        ACIONAR   = 2'b10,
        PAUSA     = 2'b11
    } estado_t;

    estado_t               state_q, state_d;
    logic [N_CANAIS-1:0]   ad_q, ad_d;
    logic [N_CANAIS-1:0]   a_q, a_d;
    logic [N_CANAIS-1:0]   pend_q, pend_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [SEL_W-1:0]      ptr_q, ptr_d;
    logic [LARG_TEMPO-1:0] timer_q, timer_d;

    logic [N_CANAIS-1:0]   elig_s;
    logic                  grant_vld_s;
    logic [SEL_W-1:0]      grant_idx_s;
    logic [N_CANAIS-1:0]   grant_clr_s;
    logic                  dose_ok_s;

    // Only channels with a pending request and no latched alarm may be granted.
    always_comb begin
        elig_s = pend_q & ~a_q;
    end

    // Round-robin arbiter: first eligible channel at or above ptr, wrapping.
    always_comb begin
        int idx_v;
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        idx_v       = 0;
        for (int j = 0; j < N_CANAIS; j++) begin
            idx_v = int'(ptr_q) + j;
            if (idx_v >= N_CANAIS) begin
                idx_v = idx_v - N_CANAIS;
            end else begin
                idx_v = idx_v;
            end
            if (!grant_vld_s && elig_s[SEL_W'(idx_v)]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = SEL_W'(idx_v);
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // Mechanism FSM: grant, timed actuation (abortable by the channel's fault), pause.
    always_comb begin
        state_d     = state_q;
        ad_d        = ad_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        timer_d     = timer_q;
        grant_clr_s = '0;
        dose_ok_s   = 1'b0;
        case (state_q)
            ESPERAR: begin
                ad_d = '0;
                if (grant_vld_s) begin
                    state_d     = ACIONAR;
                    sel_d       = grant_idx_s;
                    ad_d        = BIT0 << grant_idx_s;
                    grant_clr_s = BIT0 << grant_idx_s;
                    timer_d     = T_ACIONAR;
                    if (int'(grant_idx_s) == N_CANAIS - 1) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = grant_idx_s + SEL_W'(1);
                    end
                end else begin
                    state_d = ESPERAR;
                end
            end
            ACIONAR: begin
                if (bus.BZ[sel_q]) begin
                    // Fault on the active channel: stop at once, dose not counted.
                    ad_d    = '0;
                    state_d = PAUSA;
                    timer_d = T_PAUSA;
                end else if (timer_q == '0) begin
                    ad_d      = '0;
                    state_d   = PAUSA;
                    timer_d   = T_PAUSA;
                    dose_ok_s = 1'b1;
                end else begin
                    timer_d = timer_q - T_UM;
                end
            end
            PAUSA: begin
                ad_d = '0;
                if (timer_q == '0) begin
                    state_d = ESPERAR;
                end else begin
                    timer_d = timer_q - T_UM;
                end
            end
            default: begin
                // Unused encoding: recover to idle with the actuator off.
                state_d = ESPERAR;
                ad_d    = '0;
            end
        endcase
    end

    // Per-channel alarm and request latches; fault beats clear, and a request
    // is accepted only when the channel is neither alarmed nor faulting.
    always_comb begin
        a_d    = a_q;
        pend_d = pend_q & ~grant_clr_s;
        for (int i = 0; i < N_CANAIS; i++) begin
            if (bus.BZ[i]) begin
                a_d[i]    = 1'b1;
                pend_d[i] = 1'b0;
            end else begin
                if (bus.CLR[i]) begin
                    a_d[i] = 1'b0;
                end else begin
                    a_d[i] = a_q[i];
                end
                pend_d[i] = pend_d[i] | (bus.CR[i] & ~a_q[i]);
            end
        end
    end

    // State and datapath registers; reset drops the actuator immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ESPERAR;
            ad_q    <= '0;
            a_q     <= '0;
            pend_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            ad_q    <= ad_d;
            a_q     <= a_d;
            pend_q  <= pend_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            timer_q <= timer_d;
        end
    end

    // Drive the registered outputs onto the bundle.
    always_comb begin
        bus.AD       = ad_q;
        bus.A        = a_q;
        bus.pendente = pend_q;
        bus.state    = state_q;
        bus.sel      = sel_q;
    end

`ifdef DISPENSADOR_CONTADOR_EN
    logic [7:0] doses_q [N_CANAIS];
    logic [7:0] doses_d [N_CANAIS];

    // Saturating completed-dose counters, cleared together with the alarm.
    always_comb begin
        for (int i = 0; i < N_CANAIS; i++) begin
            doses_d[i] = doses_q[i];
            if (dose_ok_s && (sel_q == SEL_W'(i)) && (doses_q[i] != 8'hFF)) begin
                doses_d[i] = doses_q[i] + 8'd1;
            end else begin
                doses_d[i] = doses_q[i];
            end
            if (bus.CLR[i] && !bus.BZ[i]) begin
                doses_d[i] = 8'd0;
            end else begin
                doses_d[i] = doses_d[i];
            end
        end
    end

    // Dose counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CANAIS; i++) begin
                doses_q[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < N_CANAIS; i++) begin
                doses_q[i] <= doses_d[i];
            end
        end
    end

    // Pack the counters onto the bundle, channel i in bits [8i+7:8i].
    always_comb begin
        bus.doses = '0;
        for (int i = 0; i < N_CANAIS; i++) begin
            bus.doses[8*i +: 8] = doses_q[i];
        end
    end
`endif

endmodule
